// File: rtl/pin_debounce.sv
// Multi-channel GPIO debouncer: per-pin synchroniser, enable-strobed stability
// counter, registered filtered level and one-cycle rise/fall/changed pulses.
module pin_debounce #(
  parameter int               WIDTH       = 8,
  parameter int               STABLE      = 2,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             ena,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int             CW      = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] samp;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  assign samp = sync_q[SYNC_STAGES-1];

  // The synchroniser shifts every cycle; only the filter honours ena.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= din;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_q[st-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic mismatch;
      logic accept;

      assign mismatch = ena && (samp[gi] != dout_q[gi]);
      assign accept   = mismatch && (cnt_q[gi] == CNT_MAX);

      // Any enabled sample that agrees with dout, or an acceptance, clears the run.
      assign cnt_d[gi]  = !ena                   ? cnt_q[gi] :
                          (mismatch && !accept)  ? cnt_q[gi] + CW'(1) :
                                                   '0;
      assign dout_d[gi] = accept ? samp[gi] : dout_q[gi];
      assign rise_d[gi] = accept &  samp[gi];
      assign fall_d[gi] = accept & ~samp[gi];
    end
  endgenerate

  assign changed_d = |(rise_d | fall_d);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        cnt_q[ch] <= '0;
      end
      dout_q    <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
      dout_q    <= dout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: doc/pin_debounce.md
PIN_DEBOUNCE -- requirements
Module: pin_debounce

Interface
REQ-001 Parameter WIDTH, default 8: number of independent GPIO channels, legal range 1..32.
REQ-002 Parameter STABLE, default 2: consecutive enabled samples of a new level needed to accept it, legal range 1..15.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal range 1..3.
REQ-004 Parameter RESET_VAL, default all ones, WIDTH bits: reset level of dout and of every synchroniser flop.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-007 din  input  WIDTH  raw asynchronous pin levels.
REQ-008 ena  input  1  sample strobe; the filter samples and counts only on cycles where ena=1.
REQ-009 dout  output  WIDTH  filtered level, registered.
REQ-010 rise  output  WIDTH  one-cycle pulse per channel when dout goes 0->1, registered.
REQ-011 fall  output  WIDTH  one-cycle pulse per channel when dout goes 1->0, registered.
REQ-012 changed  output  1  registered OR of rise|fall, asserted in the same cycle as the pulses.

Function
REQ-013 Each channel passes din through SYNC_STAGES flops clocked every cycle, regardless of ena; s[i] is the last stage.
REQ-014 Each channel has a counter cnt[i], clog2(STABLE) bits (minimum 1 bit), which saturates at no value beyond STABLE-1.
REQ-015 Edge with ena=1 and s[i]!=dout[i], cnt[i]<STABLE-1: cnt[i]<=cnt[i]+1; dout[i] holds.
REQ-016 Edge with ena=1 and s[i]!=dout[i], cnt[i]==STABLE-1: dout[i]<=s[i]; cnt[i]<=0; rise[i] or fall[i]<=1 per direction.
REQ-017 Edge with ena=1 and s[i]==dout[i]: cnt[i]<=0, so any mismatch run shorter than STABLE samples is discarded.
REQ-018 Edge with ena=0: cnt and dout hold; the synchroniser still shifts.
REQ-019 rise, fall and changed are 0 on every edge not covered by REQ-016, so each pulse lasts exactly one clk cycle.
REQ-020 Latency with ena held 1: a din step settled before edge k appears on dout after edge k+SYNC_STAGES+STABLE-1 (defaults: k+3).
REQ-021 STABLE=1: dout follows s on the first enabled differing sample, with no filtering beyond synchronisation.
REQ-022 Channels are fully independent; simultaneous transitions on several channels each produce their own pulse in the same cycle.
REQ-023 A level that returns to dout before acceptance produces no pulse, and the counter restarts from 0 on the next mismatch.

Reset
REQ-024 On an edge with reset_n=0, independent of ena, the following load: dout<=RESET_VAL, all synchroniser flops<=RESET_VAL, cnt<=0, rise<=0, fall<=0, changed<=0.
REQ-025 Reset asserted mid-count discards the partial count.
REQ-026 First edge after reset release: no rise/fall pulse is generated unless a new level meets REQ-016 in full.
REQ-027 Reset takes priority over ena and over any pending acceptance on the same edge.

Verification
REQ-028 Defaults, ena=1, din[0] 1->0 held: fall[0]=1 and changed=1 for exactly one cycle, 3 edges after the step; dout[0]=0 afterwards.
REQ-029 Defaults, ena=1, din[3] 1-cycle low glitch: dout[3] stays 1, no pulses; repeat with a 2-cycle glitch -> fall[3] then rise[3], 2 cycles apart.
REQ-030 STABLE=4, ena toggling 1,0,1,0..., din[1] 1->0 held: dout[1] falls only after 4 enabled samples; cnt holds across ena=0 cycles.
REQ-031 din=8'h00 stepped to 8'hA5 at once, ena=1: rise=8'hA5 in a single cycle, changed=1, fall=0.
REQ-032 Reset asserted when cnt=STABLE-1 with din differing: dout=RESET_VAL and all pulses 0 next cycle; after release the full STABLE count is needed again.
REQ-033 RESET_VAL=8'h0F with din=8'h0F through reset release: no pulses in the 10 cycles after release.
